// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the raster/draw-pipeline signals of vga_timing_gen.
//   master : the timing generator (drives counters, strobes and VGA pins,
//            receives pixel_rgb from the draw pipeline)
//   slave  : the draw pipeline / display side
// Signals:
//   pixel_rgb    [11:0]  colour from the draw pipeline
//   draw_x       [10:0]  current horizontal count
//   draw_y       [9:0]   current vertical count
//   active               visible-area flag, same cycle as draw_x/draw_y
//   frame_start          one-clock pulse at (0,0)
//   vblank_start         one-clock pulse at (0,V_ACTIVE)
//   vga_hs/vga_vs/vga_de sync and data enable, delayed to match the renderers
//   vga_rgb      [11:0]  pixel_rgb gated by vga_de
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [11:0] pixel_rgb;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic        active;
  logic        frame_start;
  logic        vblank_start;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [11:0] vga_rgb;

  modport master (
    input  pixel_rgb,
    output draw_x, draw_y, active, frame_start, vblank_start,
    output vga_hs, vga_vs, vga_de, vga_rgb
  );

  modport slave (
    output pixel_rgb,
    input  draw_x, draw_y, active, frame_start, vblank_start,
    input  vga_hs, vga_vs, vga_de, vga_rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster scan generator for 1280x800@60. Exposes the live scan position
//   (draw_x/draw_y) to the renderers and delays sync/data-enable by the
//   renderers' fixed latency so the returned pixel_rgb lines up with the pins.
// Ports:
//   clk  : pixel clock
//   rst  : synchronous active-high reset
//   bus  : vga_timing_gen_if.master (pixel_rgb in; scan position, strobes and
//          VGA pins out)
// Parameters: horizontal/vertical active, porch and sync lengths, sync
//   polarities, and PIPE_DELAY (1..4) = draw-pipeline latency in clocks.
//   H_TOTAL must not exceed 2048 and V_TOTAL must not exceed 1024.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 64,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 200,
  parameter int V_ACTIVE   = 800,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 27,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b1,
  parameter int PIPE_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Stage word layout: {hs, vs, de}. Idle = both syncs inactive, no data.
  localparam logic [2:0] STAGE_IDLE = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

  // -------------------------------------------------------------------------
  // Scan counters
  // -------------------------------------------------------------------------
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;

  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      // Line and frame wrap on the same clock, so (last,last) -> (0,0).
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // -------------------------------------------------------------------------
  // Undelayed timing, decoded from the current counters
  // -------------------------------------------------------------------------
  logic       h_in_sync;
  logic       v_in_sync;
  logic       active_raw;
  logic [2:0] stage_in;

  assign h_in_sync  = (x_q >= HS_BEGIN) && (x_q < HS_END);
  // Vertical window depends only on y, so it moves at line boundaries.
  assign v_in_sync  = (y_q >= VS_BEGIN) && (y_q < VS_END);
  assign active_raw = (x_q < H_VIS) && (y_q < V_VIS);
  assign stage_in   = {h_in_sync ? H_SYNC_POL : ~H_SYNC_POL,
                       v_in_sync ? V_SYNC_POL : ~V_SYNC_POL,
                       active_raw};

  // -------------------------------------------------------------------------
  // Delay line: hs/vs/de travel together so sync-to-DE skew is always zero.
  // Reset forces every stage idle, cutting any sync pulse in flight.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
    logic [2:0] stage_q;
    logic [2:0] stage_d;

    if (gi == 0) begin : g_head
      assign stage_d = stage_in;
    end else begin : g_tail
      assign stage_d = g_stage[gi-1].stage_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= STAGE_IDLE;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  logic [2:0] pipe_out;
  assign pipe_out = g_stage[PIPE_DELAY-1].stage_q;

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.draw_x       = x_q;
  assign bus.draw_y       = y_q;
  // Strobes are gated by rst so game logic never sees a pulse from the
  // pre-reset counter position.
  assign bus.active       = ~rst & active_raw;
  assign bus.frame_start  = ~rst & (x_q == '0) & (y_q == '0);
  assign bus.vblank_start = ~rst & (x_q == '0) & (y_q == V_VIS);
  assign bus.vga_hs       = pipe_out[2];
  assign bus.vga_vs       = pipe_out[1];
  assign bus.vga_de       = pipe_out[0];
  assign bus.vga_rgb      = pipe_out[0] ? bus.pixel_rgb : 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generators share one clock:
//     g_dut[0] : full 1280x800 timing, PIPE_DELAY=1 (line-level tests)
//     g_dut[1] : shrunken 16x6 raster (25x11 totals), PIPE_DELAY=1
//                (frame-level and mid-frame reset tests)
//     g_dut[2] : shrunken raster, PIPE_DELAY=3, inverted sync polarities
//   Each instance has a scoreboard: every clock the expected {hs,vs,de} for
//   the current scan position is pushed and the entry from PIPE_DELAY clocks
//   earlier is popped and compared against the pins.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [11:0] pix = 12'hABC;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int HA = (gi == 0) ? 1280 : 16;
    localparam int HF = (gi == 0) ? 64   : 2;
    localparam int HS = (gi == 0) ? 136  : 3;
    localparam int HB = (gi == 0) ? 200  : 4;
    localparam int VA = (gi == 0) ? 800  : 6;
    localparam int VF = 1;
    localparam int VS = (gi == 0) ? 3    : 2;
    localparam int VB = (gi == 0) ? 27   : 2;
    localparam int PD = (gi == 2) ? 3    : 1;
    localparam bit HP = (gi == 2);
    localparam bit VP = (gi != 2);
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    vga_timing_gen_if bus ();
    assign bus.pixel_rgb = pix;

    vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(HP), .V_SYNC_POL(VP), .PIPE_DELAY(PD)
    ) u_dut (
      .clk (clk),
      .rst (rst[gi]),
      .bus (bus)
    );

    int         mx = 0;
    int         my = 0;
    bit         en = 1'b0;
    logic [2:0] sb[$];
    logic [2:0] exp_c;
    logic [2:0] exp_v;
    logic [11:0] exp_rgb;

    always begin
      @(negedge clk);
      if (en) begin
        checks++;
        if (bus.draw_x !== 11'(mx) || bus.draw_y !== 10'(my)) begin
          errors++;
          $display("FAIL sb%0d_counters: got (%0d,%0d) want (%0d,%0d)",
                   gi, bus.draw_x, bus.draw_y, mx, my);
        end
        exp_c = rst[gi] ? 3'b000 :
                {(mx < HA) && (my < VA), (mx == 0) && (my == 0), (mx == 0) && (my == VA)};
        checks++;
        if ({bus.active, bus.frame_start, bus.vblank_start} !== exp_c) begin
          errors++;
          $display("FAIL sb%0d_strobes at (%0d,%0d): got act/fs/vb=%b want %b",
                   gi, mx, my, {bus.active, bus.frame_start, bus.vblank_start}, exp_c);
        end
        exp_v   = sb[0];
        exp_rgb = exp_v[0] ? pix : 12'h000;
        checks++;
        if ({bus.vga_hs, bus.vga_vs, bus.vga_de} !== exp_v || bus.vga_rgb !== exp_rgb) begin
          errors++;
          $display("FAIL sb%0d_pins at (%0d,%0d): got hs/vs/de=%b rgb=%h want %b rgb=%h",
                   gi, mx, my, {bus.vga_hs, bus.vga_vs, bus.vga_de}, bus.vga_rgb, exp_v, exp_rgb);
        end
      end
      if (rst[gi]) begin
        mx = 0;
        my = 0;
        sb.delete();
        for (int k = 0; k < PD; k++) sb.push_back({!HP, !VP, 1'b0});
        en = 1'b1;
      end else if (en) begin
        void'(sb.pop_front());
        sb.push_back({((mx >= HA + HF) && (mx < HA + HF + HS)) ? HP : !HP,
                      ((my >= VA + VF) && (my < VA + VF + VS)) ? VP : !VP,
                      (mx < HA) && (my < VA)});
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 3'b111;
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    #1;
    checks++;
    if (g_dut[0].bus.draw_x !== 11'd0 || g_dut[0].bus.draw_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_counters: got (%0d,%0d) want (0,0)", g_dut[0].bus.draw_x, g_dut[0].bus.draw_y);
    end
    checks++;
    if (g_dut[0].bus.frame_start !== 1'b1 || g_dut[0].bus.active !== 1'b1) begin
      errors++;
      $display("FAIL reset_frame_start: got fs=%b act=%b want 1 1", g_dut[0].bus.frame_start, g_dut[0].bus.active);
    end
    checks++;
    if ({g_dut[0].bus.vga_hs, g_dut[0].bus.vga_vs, g_dut[0].bus.vga_de} !== 3'b100 ||
        g_dut[0].bus.vga_rgb !== 12'h000) begin
      errors++;
      $display("FAIL reset_pins: got hs/vs/de=%b rgb=%h want 100 rgb=000",
               {g_dut[0].bus.vga_hs, g_dut[0].bus.vga_vs, g_dut[0].bus.vga_de}, g_dut[0].bus.vga_rgb);
    end
    checks++;
    if ({g_dut[2].bus.vga_hs, g_dut[2].bus.vga_vs, g_dut[2].bus.vga_de} !== 3'b010) begin
      errors++;
      $display("FAIL reset_pins_invpol: got hs/vs/de=%b want 010",
               {g_dut[2].bus.vga_hs, g_dut[2].bus.vga_vs, g_dut[2].bus.vga_de});
    end
  endtask

  // One full 1680-clock line on the full-size generator.
  task automatic test_line();
    int act_cnt  = 0;
    int hs_low   = 0;
    int hs_first = -1;
    for (int i = 0; i < 1680; i++) begin
      @(negedge clk);
      if (g_dut[0].bus.active) act_cnt++;
      if (g_dut[0].bus.vga_hs === 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_low++;
      end
      if (i == 1280) begin
        checks++;
        if (g_dut[0].bus.vga_rgb !== 12'hABC) begin
          errors++;
          $display("FAIL rgb_last_pixel: got %h want abc", g_dut[0].bus.vga_rgb);
        end
      end
      if (i == 1281) begin
        checks++;
        if (g_dut[0].bus.vga_rgb !== 12'h000) begin
          errors++;
          $display("FAIL rgb_hblank: got %h want 000", g_dut[0].bus.vga_rgb);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (g_dut[0].bus.draw_x !== 11'd0 || g_dut[0].bus.draw_y !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", g_dut[0].bus.draw_x, g_dut[0].bus.draw_y);
    end
    checks++;
    if (act_cnt != 1280) begin
      errors++;
      $display("FAIL line_active_count: got %0d want 1280", act_cnt);
    end
    checks++;
    if (hs_low != 136 || hs_first != 1345) begin
      errors++;
      $display("FAIL line_hsync: got width=%0d start=%0d want width=136 start=1345", hs_low, hs_first);
    end
  endtask

  // Changing pixel data must pass straight through while vga_de is high.
  task automatic test_rgb();
    bit found = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1 pix = 12'($urandom_range(0, 4095));
      @(negedge clk);
      checks++;
      if (g_dut[0].bus.vga_rgb !== pix) begin
        errors++;
        $display("FAIL rgb_pass x=%0d: got %h want %h", k, g_dut[0].bus.vga_rgb, pix);
      end
    end
    @(posedge clk);
    #1 pix = 12'hABC;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (g_dut[1].bus.draw_x == 11'd5 && g_dut[1].bus.draw_y == 10'd7) found = 1'b1;
    end
    checks++;
    if (!found || g_dut[1].bus.vga_de !== 1'b0 || g_dut[1].bus.vga_rgb !== 12'h000) begin
      errors++;
      $display("FAIL rgb_vblank: found=%0d got de=%b rgb=%h want de=0 rgb=000",
               found, g_dut[1].bus.vga_de, g_dut[1].bus.vga_rgb);
    end
  endtask

  // One frame of the small generator, measured from a frame_start pulse.
  task automatic test_frame(input string tag);
    bit found    = 1'b0;
    int period   = -1;
    int vb_cnt   = 0;
    int vb_at    = -1;
    int vs_cnt   = 0;
    int vs_first = -1;
    int de_cnt   = 0;
    int hs_cnt   = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (g_dut[1].bus.frame_start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_wait_frame: got no frame_start want one within 600 clocks", tag);
    end else begin
      for (int k = 0; k < 600; k++) begin
        if (k > 0) @(negedge clk);
        if (k > 0 && g_dut[1].bus.frame_start) begin
          period = k;
          break;
        end
        if (g_dut[1].bus.vblank_start) begin vb_cnt++; vb_at = k; end
        if (g_dut[1].bus.vga_vs === 1'b1) begin
          if (vs_first < 0) vs_first = k;
          vs_cnt++;
        end
        if (g_dut[1].bus.vga_de === 1'b1) de_cnt++;
        if (g_dut[1].bus.vga_hs === 1'b0) hs_cnt++;
      end
      checks++;
      if (period != 275) begin
        errors++;
        $display("FAIL %s_period: got %0d want 275", tag, period);
      end
      checks++;
      if (vb_cnt != 1 || vb_at != 150) begin
        errors++;
        $display("FAIL %s_vblank: got count=%0d at=%0d want count=1 at=150", tag, vb_cnt, vb_at);
      end
      checks++;
      if (vs_cnt != 50 || vs_first != 176) begin
        errors++;
        $display("FAIL %s_vsync: got width=%0d start=%0d want width=50 start=176", tag, vs_cnt, vs_first);
      end
      checks++;
      if (de_cnt != 96 || hs_cnt != 33) begin
        errors++;
        $display("FAIL %s_de_hs: got de=%0d hs_low=%0d want de=96 hs_low=33", tag, de_cnt, hs_cnt);
      end
    end
  endtask

  // Reset mid-frame (once in the visible area, once inside both sync pulses).
  task automatic test_mid_reset();
    int tx;
    int ty;
    bit found;
    for (int t = 0; t < 2; t++) begin
      tx    = (t == 0) ? 9 : 18;
      ty    = (t == 0) ? 3 : 7;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
        @(negedge clk);
        if (g_dut[1].bus.draw_x == 11'(tx) && g_dut[1].bus.draw_y == 10'(ty)) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL mid_reset%0d_wait: got no (%0d,%0d) want it within 600 clocks", t, tx, ty);
      end
      @(posedge clk);
      #1 rst[1] = 1'b1;
      #1;
      checks++;
      if (g_dut[1].bus.active !== 1'b0 || g_dut[1].bus.frame_start !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset%0d_gate: got act=%b fs=%b want 0 0", t, g_dut[1].bus.active, g_dut[1].bus.frame_start);
      end
      @(posedge clk);
      #1 rst[1] = 1'b0;
      #1;
      checks++;
      if (g_dut[1].bus.draw_x !== 11'd0 || g_dut[1].bus.draw_y !== 10'd0 || g_dut[1].bus.frame_start !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset%0d_counters: got (%0d,%0d) fs=%b want (0,0) fs=1",
                 t, g_dut[1].bus.draw_x, g_dut[1].bus.draw_y, g_dut[1].bus.frame_start);
      end
      checks++;
      if ({g_dut[1].bus.vga_hs, g_dut[1].bus.vga_vs, g_dut[1].bus.vga_de} !== 3'b100) begin
        errors++;
        $display("FAIL mid_reset%0d_pins: got hs/vs/de=%b want 100",
                 t, {g_dut[1].bus.vga_hs, g_dut[1].bus.vga_vs, g_dut[1].bus.vga_de});
      end
    end
  endtask

  // PIPE_DELAY=3 instance: every pin edge lands 3 clocks after its cause.
  task automatic test_pipe_delay();
    int   c_act = -1, c_de  = -1;
    int   c_hs  = -1, c_hse = -1;
    int   c_vs  = -1, c_vse = -1;
    logic p_act = 1'b1, p_de = 1'b1, p_hs = 1'b1, p_vs = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (c_act < 0 && !p_act && g_dut[2].bus.active) c_act = c;
        if (c_act >= 0 && c_de < 0 && !p_de && g_dut[2].bus.vga_de) c_de = c;
        if (c_hs < 0 && g_dut[2].bus.draw_x == 11'd18) c_hs = c;
        if (c_hs >= 0 && c_hse < 0 && !p_hs && g_dut[2].bus.vga_hs) c_hse = c;
        if (c_vs < 0 && g_dut[2].bus.draw_x == 11'd0 && g_dut[2].bus.draw_y == 10'd7) c_vs = c;
        if (c_vs >= 0 && c_vse < 0 && p_vs && !g_dut[2].bus.vga_vs) c_vse = c;
      end
      p_act = g_dut[2].bus.active;
      p_de  = g_dut[2].bus.vga_de;
      p_hs  = g_dut[2].bus.vga_hs;
      p_vs  = g_dut[2].bus.vga_vs;
    end
    checks++;
    if (c_act < 0 || c_de - c_act != 3) begin
      errors++;
      $display("FAIL pd3_de_delay: got act_rise=%0d de_rise=%0d want de 3 clocks later", c_act, c_de);
    end
    checks++;
    if (c_hs < 0 || c_hse - c_hs != 3) begin
      errors++;
      $display("FAIL pd3_hs_delay: got window=%0d pin=%0d want pin 3 clocks later", c_hs, c_hse);
    end
    checks++;
    if (c_vs < 0 || c_vse - c_vs != 3) begin
      errors++;
      $display("FAIL pd3_vs_delay: got window=%0d pin=%0d want pin 3 clocks later", c_vs, c_vse);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_rgb();
    test_frame("frame");
    test_mid_reset();
    test_frame("frame_after_reset");
    test_pipe_delay();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster scan for the 1280x800@60 display.
- Outputs draw_x/draw_y, which every drawcon_* overlay and sprite renderer consumes.
- Delays sync and data-enable by the renderers' fixed ROM latency, so pixel_rgb returned by the draw pipeline lines up with the VGA pins.
- Also generates frame_start and vblank_start pulses for game-state logic, including the game-over screen switch.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 64, horizontal front porch (clocks)
H_SYNC, 136, horizontal sync width (clocks)
H_BP, 200, horizontal back porch (clocks)
V_ACTIVE, 800, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BP, 27, vertical back porch (lines)
H_SYNC_POL, 0, active level of vga_hs
V_SYNC_POL, 1, active level of vga_vs
PIPE_DELAY, 1, draw-pipeline latency in clocks; legal range 1..4

Ports:
clk  input  1  pixel clock (83.46 MHz)
rst  input  1  synchronous active-high reset
pixel_rgb  input  12  colour from the draw pipeline, valid PIPE_DELAY clocks after the matching draw_x/draw_y
draw_x  output  11  current horizontal count, 0..H_TOTAL-1
draw_y  output  10  current vertical count, 0..V_TOTAL-1
active  output  1  draw_x < H_ACTIVE and draw_y < V_ACTIVE, same cycle as draw_x/draw_y
frame_start  output  1  one-clock pulse when draw_x==0 and draw_y==0
vblank_start  output  1  one-clock pulse when draw_x==0 and draw_y==V_ACTIVE
vga_hs  output  1  horizontal sync, delayed PIPE_DELAY clocks
vga_vs  output  1  vertical sync, delayed PIPE_DELAY clocks
vga_de  output  1  data enable (active delayed PIPE_DELAY clocks)
vga_rgb  output  12  pixel_rgb when vga_de, else 12'h000

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All registers update on posedge clk only.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1680; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 831.
- Counters: draw_x and draw_y are registered counters.
  - draw_x increments every clock and wraps H_TOTAL-1 -> 0.
  - draw_y increments only on the cycle draw_x wraps, and wraps V_TOTAL-1 -> 0 on that same cycle. At (1679,830) the next value is (0,0).
- Sync windows, computed from the current counters:
  - hsync_raw = H_SYNC_POL when H_ACTIVE+H_FP <= draw_x < H_ACTIVE+H_FP+H_SYNC (1344..1479), else !H_SYNC_POL.
  - vsync_raw = V_SYNC_POL when V_ACTIVE+V_FP <= draw_y < V_ACTIVE+V_FP+V_SYNC (801..803), else !V_SYNC_POL. The vertical window is line-granular and changes only at draw_x==0.
- active, frame_start and vblank_start are combinational from the counters.
  - All three are forced to 0 while rst is high.
  - frame_start is high in the first clock after rst deasserts, because the counters are at 0.
- Delay line: PIPE_DELAY register stages carry {hsync_raw, vsync_raw, active}. The stage-PIPE_DELAY outputs drive vga_hs, vga_vs and vga_de.
- vga_rgb = vga_de ? pixel_rgb : 12'h000 (combinational). pixel_rgb is ignored during blanking.
- Reset values:
  - draw_x = 0, draw_y = 0.
  - All delay stages: hs = !H_SYNC_POL, vs = !V_SYNC_POL, de = 0.
  - Hence vga_de = 0 and vga_rgb = 0 in reset.
- Reset mid-frame: the cycle after rst is sampled high, the counters read (0,0) and the delay stages hold their inactive levels. No partial sync pulse may extend past reset.
- Width: counter compares use the full port widths; parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024.
- Latency: an event at counter value (x,y) appears on vga_* exactly PIPE_DELAY clocks later. The delay is identical for hs, vs and de, so sync-to-DE skew is 0.

Test Plan:
- Release rst at cycle 0 -> draw_x=0, draw_y=0, frame_start=1 in that cycle; vga_de=0, vga_hs=1, vga_vs=0 (PIPE_DELAY=1).
- Run one line -> draw_x counts 0..1679 then 0 and draw_y steps 0->1; active high for exactly 1280 clocks; vga_hs low for exactly 136 clocks starting 1345 clocks after draw_x=0.
- Run a full frame -> frame_start period exactly 1680*831 = 1,396,080 clocks; vblank_start once at (0,800); vga_vs high for 3*1680 = 5040 clocks starting 1 clock after draw_y becomes 801.
- Drive pixel_rgb = 12'hABC constant -> vga_rgb = 12'hABC only while vga_de; vga_rgb = 12'h000 at draw_x=1280 delayed by 1 and throughout vertical blanking.
- Assert rst for 1 clock at (700,400) -> next cycle (0,0), vga_de=0, vga_hs=1, vga_vs=0; the following frame's timing is identical to the first frame.
- PIPE_DELAY=3 -> vga_de rises exactly 3 clocks after active rises; hs/vs/de edges remain mutually aligned.
